// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - row-major serial stream to parallel matrix loader with framing checks
module matrix_stream_loader #(
    parameter  int ROWS       = 12,
    parameter  int COLS       = 12,
    parameter  int DATA_WIDTH = 64,
    localparam int NUM_ELEM   = ROWS * COLS,
    localparam int CNT_W      = $clog2(NUM_ELEM + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_sof,
    input  logic                             in_last,
    output logic [NUM_ELEM*DATA_WIDTH-1:0]   mat_out,
    output logic                             mat_valid,
    input  logic                             mat_ack,
    output logic                             frame_err,
    output logic [CNT_W-1:0]                 load_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Row-major order means the element count doubles as the linear write
    // index: element [r][c] lives at slot r*COLS+c, the slot written on the
    // (r*COLS+c)-th beat of the frame.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic [NUM_ELEM*DATA_WIDTH-1:0]  mat_q, mat_d;

    logic                            accept;
    logic                            wr_en;
    logic [CNT_W-1:0]                wr_idx;

    // Ready comes from registered state only so it never depends on in_valid.
    assign in_ready   = (state_q != ST_HOLD);
    assign accept     = in_valid && in_ready;
    assign mat_valid  = (state_q == ST_HOLD);
    assign frame_err  = err_q;
    assign load_count = cnt_q;
    assign mat_out    = mat_q;

    // Frame sequencing: next state, element count, write strobe and error pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        cnt_d  = CNT_W'(1);
                        if (NUM_ELEM == 1) begin
                            // The first element is also the final one.
                            state_d = ST_HOLD;
                            err_d   = !in_last;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        // Beat outside a frame: dropped and flagged.
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (in_sof) begin
                        // Restart wins over a simultaneous last; one pulse only.
                        wr_idx = '0;
                        cnt_d  = CNT_W'(1);
                        err_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            // Matrix is delivered even when last is missing.
                            state_d = ST_HOLD;
                            err_d   = !in_last;
                        end else if (in_last) begin
                            // Short frame: abandon it, written elements remain.
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (mat_ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Matrix storage update: only the addressed element changes, others persist across frames.
    always_comb begin
        mat_d = mat_q;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (wr_en && (wr_idx == CNT_W'(i))) begin
                mat_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
    end

    // State, count, error pulse and matrix registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mat_q   <= mat_d;
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb/tb_matrix_stream_loader.sv - randomized self-checking bench for matrix_stream_loader
module tb_matrix_stream_loader;

    localparam int R    = 12;
    localparam int C    = 12;
    localparam int DW   = 64;
    localparam int N    = R * C;
    localparam int CNTW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_sof = 1'b0;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] mat_out;
    logic            mat_valid;
    logic            mat_ack = 1'b0;
    logic            frame_err;
    logic [CNTW-1:0] load_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: linear element position, frame phase (0 idle, 1 loading, 2 held)
    int            m_phase = 0;
    int            m_cnt   = 0;
    bit            m_err   = 1'b0;
    logic [DW-1:0] exp_mat [N];
    bit            gap_en  = 1'b0;

    matrix_stream_loader #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_last    (in_last),
        .mat_out    (mat_out),
        .mat_valid  (mat_valid),
        .mat_ack    (mat_ack),
        .frame_err  (frame_err),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mat_diff();
        int d = 0;
        for (int i = 0; i < N; i++)
            if (mat_out[i*DW +: DW] !== exp_mat[i]) d++;
        return d;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic stop_stream();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drive one beat until accepted, then advance the reference model.
    task automatic send_beat(input logic [DW-1:0] d, input bit s, input bit l);
        int w = 0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1; in_data = d; in_sof = s; in_last = l;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            stop_stream();
            return;
        end
        @(posedge clk); #1;
        if (m_phase == 0) begin
            if (s) begin
                exp_mat[0] = d; m_cnt = 1; m_phase = 1; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            if (s) begin
                exp_mat[0] = d; m_cnt = 1; m_err = 1'b1;
            end else begin
                exp_mat[m_cnt] = d;
                m_cnt++;
                if (m_cnt == N) begin
                    m_phase = 2; m_err = !l;
                end else if (l) begin
                    m_phase = 0; m_cnt = 0; m_err = 1'b1;
                end else begin
                    m_err = 1'b0;
                end
            end
        end
    endtask

    // Send beats [first, last_beat] of a frame; counts beats where frame_err was high.
    task automatic send_range(input int first, input int last_beat, input bit last_ok,
                              input bit seq_data, output int err_beats);
        err_beats = 0;
        for (int i = first; i <= last_beat; i++) begin
            send_beat(seq_data ? DW'(64'h1000 + i) : rnd_data(), i == 0, last_ok && (i == N-1));
            if (frame_err === 1'b1) err_beats++;
        end
        stop_stream();
    endtask

    task automatic do_ack();
        mat_ack = 1'b1;
        @(posedge clk); #1;
        mat_ack = 1'b0;
        if (m_phase == 2) begin
            m_phase = 0; m_cnt = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (mat_valid !== 1'b0 || frame_err !== 1'b0 || load_count !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%0b err=%0b cnt=%0d required 0 0 0", mat_valid, frame_err, load_count);
        end
        n_tests++;
        if (mat_out !== '0) begin
            n_fail++;
            $display("FAIL reset_matrix: mat_out nonzero, required all zero");
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int eb;
        gap_en = 1'b0;
        send_range(0, N-1, 1'b1, 1'b1, eb);
        n_tests++;
        if (mat_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_frame_valid: valid=%0b ready=%0b required 1 0", mat_valid, in_ready);
        end
        n_tests++;
        if (load_count !== CNTW'(N)) begin
            n_fail++;
            $display("FAIL full_frame_count: load_count=%0d required %0d", load_count, N);
        end
        n_tests++;
        if (mat_diff() != 0) begin
            n_fail++;
            $display("FAIL full_frame_data: %0d elements differ, required 0 (e.g. [1][5]=%0h required %0h)",
                     mat_diff(), mat_out[17*DW +: DW], 64'h1000 + 17);
        end
        n_tests++;
        if (eb != 0) begin
            n_fail++;
            $display("FAIL full_frame_err: frame_err beats=%0d required 0", eb);
        end
    endtask

    task automatic test_hold();
        logic [N*DW-1:0] snap;
        int bad = 0;
        snap = mat_out;
        in_valid = 1'b1; in_data = 64'hDEAD; in_sof = 1'b1; in_last = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (mat_out !== snap || in_ready !== 1'b0 || mat_valid !== 1'b1 || frame_err !== 1'b0) bad++;
        end
        stop_stream();
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d cycles disturbed, required 0", bad);
        end
        do_ack();
        n_tests++;
        if (mat_valid !== 1'b0 || in_ready !== 1'b1 || load_count !== '0) begin
            n_fail++;
            $display("FAIL hold_ack: valid=%0b ready=%0b cnt=%0d required 0 1 0", mat_valid, in_ready, load_count);
        end
        n_tests++;
        if (mat_diff() != 0) begin
            n_fail++;
            $display("FAIL hold_ack_data: %0d elements differ after ack, required 0", mat_diff());
        end
    endtask

    task automatic test_stray_beat();
        int eb;
        send_beat(rnd_data(), 1'b0, 1'b0);
        n_tests++;
        if (frame_err !== m_err || load_count !== CNTW'(m_cnt) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_beat: err=%0b cnt=%0d ready=%0b required %0b %0d 1", frame_err, load_count, in_ready, m_err, m_cnt);
        end
        stop_stream();
        @(posedge clk); #1;
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_pulse_width: err=%0b required 0", frame_err);
        end
        gap_en = 1'b1;
        send_range(0, N-1, 1'b1, 1'b0, eb);
        n_tests++;
        if (mat_valid !== 1'b1 || mat_diff() != 0 || eb != 0) begin
            n_fail++;
            $display("FAIL stray_then_frame: valid=%0b diff=%0d errbeats=%0d required 1 0 0", mat_valid, mat_diff(), eb);
        end
        do_ack();
    endtask

    task automatic test_restart();
        int eb;
        gap_en = 1'b1;
        send_range(0, 49, 1'b1, 1'b0, eb);
        send_beat(64'hAAAA, 1'b1, 1'b0);
        n_tests++;
        if (frame_err !== 1'b1 || load_count !== CNTW'(1) || mat_out[0 +: DW] !== 64'hAAAA) begin
            n_fail++;
            $display("FAIL restart: err=%0b cnt=%0d m00=%0h required 1 1 aaaa", frame_err, load_count, mat_out[0 +: DW]);
        end
        send_range(1, N-1, 1'b1, 1'b0, eb);
        n_tests++;
        if (mat_valid !== 1'b1 || mat_diff() != 0 || eb != 0) begin
            n_fail++;
            $display("FAIL restart_complete: valid=%0b diff=%0d errbeats=%0d required 1 0 0", mat_valid, mat_diff(), eb);
        end
        do_ack();
    endtask

    task automatic test_early_last();
        int eb;
        gap_en = 1'b0;
        send_range(0, 98, 1'b1, 1'b0, eb);
        send_beat(rnd_data(), 1'b0, 1'b1);
        n_tests++;
        if (frame_err !== 1'b1 || mat_valid !== 1'b0 || in_ready !== 1'b1 || load_count !== CNTW'(m_cnt)) begin
            n_fail++;
            $display("FAIL early_last: err=%0b valid=%0b ready=%0b cnt=%0d required 1 0 1 %0d", frame_err, mat_valid, in_ready, load_count, m_cnt);
        end
        stop_stream();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (mat_valid !== 1'b0 || mat_diff() != 0) begin
            n_fail++;
            $display("FAIL early_last_idle: valid=%0b diff=%0d required 0 0", mat_valid, mat_diff());
        end
        gap_en = 1'b1;
        send_range(0, N-1, 1'b0, 1'b0, eb);
        n_tests++;
        if (frame_err !== 1'b1 || mat_valid !== 1'b1 || mat_diff() != 0) begin
            n_fail++;
            $display("FAIL missing_last: err=%0b valid=%0b diff=%0d required 1 1 0", frame_err, mat_valid, mat_diff());
        end
        do_ack();
    endtask

    task automatic test_sof_and_last();
        int eb;
        gap_en = 1'b0;
        send_range(0, 9, 1'b1, 1'b0, eb);
        send_beat(rnd_data(), 1'b1, 1'b1);
        n_tests++;
        if (frame_err !== 1'b1 || load_count !== CNTW'(1) || in_ready !== 1'b1 || mat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_last: err=%0b cnt=%0d ready=%0b valid=%0b required 1 1 1 0", frame_err, load_count, in_ready, mat_valid);
        end
        send_beat(rnd_data(), 1'b0, 1'b0);
        n_tests++;
        if (frame_err !== 1'b0 || load_count !== CNTW'(2)) begin
            n_fail++;
            $display("FAIL sof_last_single_pulse: err=%0b cnt=%0d required 0 2", frame_err, load_count);
        end
        send_range(2, N-1, 1'b1, 1'b0, eb);
        n_tests++;
        if (mat_valid !== 1'b1 || mat_diff() != 0 || eb != 0) begin
            n_fail++;
            $display("FAIL sof_last_complete: valid=%0b diff=%0d errbeats=%0d required 1 0 0", mat_valid, mat_diff(), eb);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_frame();
        int eb;
        gap_en = 1'b1;
        send_range(0, 69, 1'b1, 1'b0, eb);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < N; i++) exp_mat[i] = '0;
        m_phase = 0; m_cnt = 0; m_err = 1'b0;
        n_tests++;
        if (mat_valid !== 1'b0 || frame_err !== 1'b0 || load_count !== '0 || mat_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b err=%0b cnt=%0d diff=%0d required 0 0 0 0", mat_valid, frame_err, load_count, mat_diff());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: in_ready=%0b required 1", in_ready);
        end
        send_range(0, N-1, 1'b1, 1'b0, eb);
        n_tests++;
        if (mat_valid !== 1'b1 || mat_diff() != 0 || load_count !== CNTW'(N) || eb != 0) begin
            n_fail++;
            $display("FAIL reset_mid_reload: valid=%0b diff=%0d cnt=%0d errbeats=%0d required 1 0 %0d 0", mat_valid, mat_diff(), load_count, eb, N);
        end
        do_ack();
    endtask

    initial begin
        for (int i = 0; i < N; i++) exp_mat[i] = '0;
        test_reset();
        test_full_frame();
        test_hold();
        test_stray_beat();
        test_restart();
        test_early_last();
        test_sof_and_last();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
